ifft_8_seq: RTL and testbench

- Sequential 8-point inverse FFT engine. It is the return path that matches the forward 8-point FFT demo datapath.
- Accepts 8 frequency-domain complex words serially and computes them in place with one time-shared radix-2 butterfly.
- Streams 8 time-domain words out in natural order, scaled by 1/8.
- Sits between the forward FFT/spectral-processing stage and the sample output.

---
 rtl/fft8_pkg.sv | 33 +++
 rtl/idft_2_bfly.sv | 70 +++++++
 rtl/ifft_8_seq.sv | 142 ++++++++++++++
 tb/tb_ifft_8_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft8_pkg.sv
// Shared types and helpers for the 8-point inverse FFT engine.
package fft8_pkg;

    localparam int WORD_SZ   = 16;
    localparam int HALF_WORD = WORD_SZ / 2;
    localparam int N_PTS     = 8;
    // cos(pi/4) in Q1.7
    localparam int TW_C      = 90;

    typedef enum logic [1:0] {
        StLoad,
        StCompute,
        StUnload
    } state_e;

    typedef struct packed {
        logic signed [HALF_WORD-1:0] re;
        logic signed [HALF_WORD-1:0] im;
    } cpx_t;

    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    function automatic cpx_t cpx_split(input logic [WORD_SZ-1:0] w);
        return cpx_t'(w);
    endfunction

    function automatic logic [WORD_SZ-1:0] cpx_pack(input cpx_t c);
        return {c.re, c.im};
    endfunction

endpackage

// File: rtl/idft_2_bfly.sv
// Combinational radix-2 inverse butterfly: P = B*W^(-t), top/bot = (A +/- P) >>> 1.
module idft_2_bfly
    import fft8_pkg::*;
(
    input  logic [WORD_SZ-1:0] i_a,
    input  logic [WORD_SZ-1:0] i_b,
    input  logic [1:0]         i_tw,
    output logic [WORD_SZ-1:0] o_top,
    output logic [WORD_SZ-1:0] o_bot
);

    localparam int PROD_W = 2 * HALF_WORD + 1;
    localparam int SUM_W  = HALF_WORD + 1;
    localparam logic signed [PROD_W-1:0] SAT_HI = PROD_W'(2 ** (HALF_WORD - 1) - 1);
    localparam logic signed [PROD_W-1:0] SAT_LO = -PROD_W'(2 ** (HALF_WORD - 1));

    function automatic logic signed [HALF_WORD-1:0] sat(input logic signed [PROD_W-1:0] v);
        if (v > SAT_HI) begin
            return SAT_HI[HALF_WORD-1:0];
        end else if (v < SAT_LO) begin
            return SAT_LO[HALF_WORD-1:0];
        end
        return v[HALF_WORD-1:0];
    endfunction

    cpx_t w_a, w_b, w_p, w_top, w_bot;
    logic signed [PROD_W-1:0] w_br, w_bi, w_rc, w_ic;
    logic signed [SUM_W-1:0]  w_sum_r, w_sum_i, w_dif_r, w_dif_i;

    assign w_a  = cpx_split(i_a);
    assign w_b  = cpx_split(i_b);
    assign w_br = PROD_W'(w_b.re);
    assign w_bi = PROD_W'(w_b.im);
    assign w_rc = w_br * PROD_W'(TW_C);
    assign w_ic = w_bi * PROD_W'(TW_C);

    always_comb begin
        w_p = w_b;
        case (i_tw)
            2'd1: begin
                w_p.re = sat((w_rc - w_ic) >>> 7);
                w_p.im = sat((w_rc + w_ic) >>> 7);
            end
            2'd2: begin
                // j*B; negating the most negative value clamps to the max
                w_p.re = sat(-w_bi);
                w_p.im = w_b.re;
            end
            2'd3: begin
                w_p.re = sat((-w_rc - w_ic) >>> 7);
                w_p.im = sat((w_rc - w_ic) >>> 7);
            end
            default: w_p = w_b;
        endcase
    end

    assign w_sum_r = SUM_W'(w_a.re) + SUM_W'(w_p.re);
    assign w_sum_i = SUM_W'(w_a.im) + SUM_W'(w_p.im);
    assign w_dif_r = SUM_W'(w_a.re) - SUM_W'(w_p.re);
    assign w_dif_i = SUM_W'(w_a.im) - SUM_W'(w_p.im);

    assign w_top.re = HALF_WORD'(w_sum_r >>> 1);
    assign w_top.im = HALF_WORD'(w_sum_i >>> 1);
    assign w_bot.re = HALF_WORD'(w_dif_r >>> 1);
    assign w_bot.im = HALF_WORD'(w_dif_i >>> 1);

    assign o_top = cpx_pack(w_top);
    assign o_bot = cpx_pack(w_bot);

endmodule

// File: rtl/ifft_8_seq.sv
// Sequential 8-point inverse FFT: bit-reversed load, 12 in-place butterflies, natural-order unload.
module ifft_8_seq
    import fft8_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [WORD_SZ-1:0] i_data,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [WORD_SZ-1:0] o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_last,
    output logic               o_busy
);

    state_e             r_state, w_state_d;
    logic [WORD_SZ-1:0] r_mem [N_PTS];
    logic [2:0]         r_in_cnt, r_out_cnt;
    logic [1:0]         r_stage, r_bfly;
    logic [WORD_SZ-1:0] r_data;
    logic               r_valid, r_last;

    logic [2:0]         w_addr_a, w_addr_b;
    logic [1:0]         w_tw;
    logic [WORD_SZ-1:0] w_top, w_bot;
    logic               w_in_fire, w_out_fire, w_last_bfly;

    assign w_in_fire   = i_valid && (r_state == StLoad);
    assign w_out_fire  = r_valid && i_ready;
    assign w_last_bfly = (r_stage == 2'd2) && (r_bfly == 2'd3);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StLoad;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        o_ready   = 1'b0;
        o_busy    = 1'b0;
        unique case (r_state)
            StLoad: begin
                o_ready = 1'b1;
                if (w_in_fire && (r_in_cnt == 3'd7)) begin
                    w_state_d = StCompute;
                end
            end
            StCompute: begin
                o_busy = 1'b1;
                if (w_last_bfly) begin
                    w_state_d = StUnload;
                end
            end
            StUnload: begin
                if (w_out_fire && r_last) begin
                    w_state_d = StLoad;
                end
            end
            default: w_state_d = StLoad;
        endcase
    end

    // Stage s pairs (a, a + 2^s); butterfly index supplies the remaining address bits
    always_comb begin
        w_addr_a = {r_bfly, 1'b0};
        w_tw     = 2'd0;
        case (r_stage)
            2'd1: begin
                w_addr_a = {r_bfly[1], 1'b0, r_bfly[0]};
                w_tw     = {r_bfly[0], 1'b0};
            end
            2'd2: begin
                w_addr_a = {1'b0, r_bfly};
                w_tw     = r_bfly;
            end
            default: ;
        endcase
        w_addr_b = w_addr_a | (3'd1 << r_stage);
    end

    idft_2_bfly u_bfly (
        .i_a   (r_mem[w_addr_a]),
        .i_b   (r_mem[w_addr_b]),
        .i_tw  (w_tw),
        .o_top (w_top),
        .o_bot (w_bot)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_PTS; i++) begin
                r_mem[i] <= '0;
            end
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_stage   <= '0;
            r_bfly    <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
        end else begin
            unique case (r_state)
                StLoad: begin
                    if (w_in_fire) begin
                        r_mem[bitrev3(r_in_cnt)] <= i_data;
                        r_in_cnt                 <= r_in_cnt + 3'd1;
                    end
                end
                StCompute: begin
                    r_mem[w_addr_a] <= w_top;
                    r_mem[w_addr_b] <= w_bot;
                    r_bfly          <= r_bfly + 2'd1;
                    if (r_bfly == 2'd3) begin
                        r_stage <= (r_stage == 2'd2) ? 2'd0 : r_stage + 2'd1;
                    end
                end
                StUnload: begin
                    // Output register refills whenever it is empty or being drained
                    if (!r_valid || (i_ready && !r_last)) begin
                        r_data    <= r_mem[r_out_cnt];
                        r_valid   <= 1'b1;
                        r_last    <= (r_out_cnt == 3'd7);
                        r_out_cnt <= r_out_cnt + 3'd1;
                    end else if (w_out_fire) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_last  = r_last;

endmodule

// File: tb/tb_ifft_8_seq.sv
// Self-checking bench for ifft_8_seq: directed and random frames against an arithmetic IDFT model.
module tb_ifft_8_seq;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [15:0] i_data = '0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;
    logic        o_ready, o_valid, o_last, o_busy;
    logic [15:0] o_data;

    int n_checks = 0;
    int n_fail   = 0;
    int in_r[8], in_i[8], exp_r[8], exp_i[8];

    ifft_8_seq dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_last  (o_last),
        .o_busy  (o_busy)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    function automatic logic [15:0] pk(input int r, input int i);
        return {r[7:0], i[7:0]};
    endfunction

    function automatic int fdiv(input int x, input int d);
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    function automatic int sat8(input int x);
        return (x > 127) ? 127 : ((x < -128) ? -128 : x);
    endfunction

    // Radix-2 DIT inverse transform with per-stage halving, computed on plain integers
    task automatic run_model();
        int mr[8], mi[8];
        for (int k = 0; k < 8; k++) begin
            int rk;
            rk = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
            mr[rk] = in_r[k];
            mi[rk] = in_i[k];
        end
        for (int s = 0; s < 3; s++) begin
            for (int a = 0; a < 8; a++) begin
                int span, t, br, bi, pr, pi;
                span = 1 << s;
                if ((a & span) == 0) begin
                    t  = (a % span) * (4 >> s);
                    br = mr[a + span];
                    bi = mi[a + span];
                    case (t)
                        1: begin
                            pr = sat8(fdiv(90 * br - 90 * bi, 128));
                            pi = sat8(fdiv(90 * br + 90 * bi, 128));
                        end
                        2: begin
                            pr = sat8(-bi);
                            pi = br;
                        end
                        3: begin
                            pr = sat8(fdiv(-90 * br - 90 * bi, 128));
                            pi = sat8(fdiv(90 * br - 90 * bi, 128));
                        end
                        default: begin
                            pr = br;
                            pi = bi;
                        end
                    endcase
                    mr[a + span] = fdiv(mr[a] - pr, 2);
                    mi[a + span] = fdiv(mi[a] - pi, 2);
                    mr[a]        = fdiv(mr[a] + pr, 2);
                    mi[a]        = fdiv(mi[a] + pi, 2);
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            exp_r[k] = mr[k];
            exp_i[k] = mi[k];
        end
    endtask

    task automatic set_const(input int k0r, input int k0i, input int restr, input int resti);
        for (int k = 0; k < 8; k++) begin
            in_r[k] = (k == 0) ? k0r : restr;
            in_i[k] = (k == 0) ? k0i : resti;
        end
        run_model();
    endtask

    task automatic set_random();
        logic [7:0] b;
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            in_r[k] = int'($signed(b));
            b = 8'($urandom);
            in_i[k] = int'($signed(b));
        end
        run_model();
    endtask

    task automatic send_frame(input bit gaps);
        int k, guard;
        bit rdy;
        k = 0;
        guard = 0;
        while (k < 8 && guard < 100) begin
            guard++;
            if (gaps && (guard % 2 == 0)) begin
                i_valid = 1'b0;
            end else begin
                i_valid = 1'b1;
                i_data  = pk(in_r[k], in_i[k]);
            end
            check("load_ready", 32'(o_ready), 32'd1);
            rdy = o_ready;
            tick();
            if (i_valid && rdy) k++;
        end
        i_valid = 1'b0;
        check("inputs_accepted", 32'(k), 32'd8);
    endtask

    task automatic wait_valid();
        int edges, busy;
        edges = 0;
        busy  = 0;
        check("ready_drop", 32'(o_ready), 32'd0);
        if (o_busy === 1'b1) busy++;
        while (o_valid !== 1'b1 && edges < 40) begin
            tick();
            edges++;
            if (o_busy === 1'b1) busy++;
        end
        check("valid_latency", 32'(edges), 32'd13);
        check("busy_cycles", 32'(busy), 32'd12);
    endtask

    // mode 0: always ready, 1: pattern 1,0,0,1, 2: random
    task automatic recv_frame(input int mode);
        int idx, cyc;
        bit rdy, fire;
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 200) begin
            case (mode)
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       rdy = 1'($urandom_range(0, 1));
                default: rdy = 1'b1;
            endcase
            i_ready = rdy;
            check("valid_ready_excl", 32'(o_valid & o_ready), 32'd0);
            if (o_valid === 1'b1) begin
                check($sformatf("data[%0d]", idx), 32'(o_data), 32'(pk(exp_r[idx], exp_i[idx])));
                check($sformatf("last[%0d]", idx), 32'(o_last), 32'(idx == 7));
            end
            fire = (o_valid === 1'b1) && rdy;
            tick();
            cyc++;
            if (fire) idx++;
        end
        i_ready = 1'b1;
        check("words_out", 32'(idx), 32'd8);
        check("back_to_load", 32'(o_ready), 32'd1);
        for (int i = 0; i < 2; i++) begin
            check("no_extra_word", 32'(o_valid), 32'd0);
            tick();
        end
    endtask

    task automatic run_frame(input bit gaps, input int mode);
        send_frame(gaps);
        wait_valid();
        recv_frame(mode);
    endtask

    initial begin
        i_rst_n = 1'b0;
        tick();
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_last", 32'(o_last), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        tick();
        i_rst_n = 1'b1;
        tick();

        set_const(8, 0, 0, 0);
        run_frame(1'b0, 0);

        set_const(16, 0, 16, 0);
        run_frame(1'b0, 0);

        set_const(16, 0, 16, 0);
        run_frame(1'b0, 1);

        set_const(8, 0, 0, 0);
        run_frame(1'b1, 0);

        // Reset while the fifth butterfly is in flight
        set_const(16, 0, 16, 0);
        send_frame(1'b0);
        repeat (4) tick();
        check("midrun_busy", 32'(o_busy), 32'd1);
        i_rst_n = 1'b0;
        #1;
        check("async_busy", 32'(o_busy), 32'd0);
        check("async_valid", 32'(o_valid), 32'd0);
        check("async_data", 32'(o_data), 32'd0);
        check("async_ready", 32'(o_ready), 32'd1);
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(o_ready), 32'd1);
        run_frame(1'b0, 0);

        for (int k = 0; k < 8; k++) begin
            in_r[k] = (k == 2) ? -128 : 0;
            in_i[k] = (k == 2) ? -128 : 0;
        end
        run_model();
        run_frame(1'b0, 0);

        for (int f = 0; f < 6; f++) begin
            set_random();
            run_frame(f[0], (f % 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
